// File: rtl/swan_bus_pkg.sv
// Shared types and default phase timing for the WonderSwan cartridge bus master.
package swan_bus_pkg;

  localparam int unsigned DEF_SETUP_CYCLES  = 2;
  localparam int unsigned DEF_STROBE_CYCLES = 4;
  localparam int unsigned DEF_HOLD_CYCLES   = 2;

  localparam int unsigned ADDR_LO_W = 9;
  localparam int unsigned ADDR_HI_W = 4;
  localparam int unsigned DATA_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef struct packed {
    logic                 write;
    logic                 io;
    logic [ADDR_LO_W-1:0] addr_lo;
    logic [ADDR_HI_W-1:0] addr_hi;
    logic [DATA_W-1:0]    wdata;
  } swan_cmd_t;

  // Largest of the three phase lengths; sizes the shared down-counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/swan_bus_master.sv
// Host-side initiator for the WonderSwan cartridge bus with programmable
// setup/strobe/hold phases and a single-cycle read response.
module swan_bus_master
  import swan_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic                 cmd_io,
  input  logic [ADDR_LO_W-1:0] cmd_addr_lo,
  input  logic [ADDR_HI_W-1:0] cmd_addr_hi,
  input  logic [DATA_W-1:0]    cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 nSel,
  output logic                 nOE,
  output logic                 nWE,
  output logic                 nIO,
  output logic [ADDR_LO_W-1:0] AddrLo,
  output logic [ADDR_HI_W-1:0] AddrHi,
  output logic [DATA_W-1:0]    DataOut,
  output logic                 DataOe,
  input  logic [DATA_W-1:0]    DataIn
);

  localparam int unsigned MAX_CYCLES = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  swan_cmd_t        cmd_q, cmd_nxt;

  logic              cmd_ready_nxt, rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt, data_out_nxt;
  logic              nsel_nxt, noe_nxt, nwe_nxt, nio_nxt, data_oe_nxt;

  logic cnt_done;
  assign cnt_done = (cnt == '0);

  // Address pins are the latched command fields, so they hold until the next accept.
  assign AddrLo = cmd_q.addr_lo;
  assign AddrHi = cmd_q.addr_hi;

  // State and registered-output update; reset returns every strobe to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cmd_q     <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      nSel      <= 1'b1;
      nOE       <= 1'b1;
      nWE       <= 1'b1;
      nIO       <= 1'b1;
      DataOut   <= '0;
      DataOe    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cmd_q     <= cmd_nxt;
      cmd_ready <= cmd_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      nSel      <= nsel_nxt;
      nOE       <= noe_nxt;
      nWE       <= nwe_nxt;
      nIO       <= nio_nxt;
      DataOut   <= data_out_nxt;
      DataOe    <= data_oe_nxt;
    end
  end

  // Phase sequencing and next values of every bus-facing register.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cmd_nxt       = cmd_q;
    cmd_ready_nxt = cmd_ready;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    nsel_nxt      = nSel;
    noe_nxt       = nOE;
    nwe_nxt       = nWE;
    nio_nxt       = nIO;
    data_out_nxt  = DataOut;
    data_oe_nxt   = DataOe;

    unique case (state)
      ST_IDLE: begin
        nsel_nxt = ~enable;
        if (cmd_valid && cmd_ready) begin
          cmd_nxt.write   = cmd_write;
          cmd_nxt.io      = cmd_io;
          cmd_nxt.addr_lo = cmd_addr_lo;
          cmd_nxt.addr_hi = cmd_addr_hi;
          cmd_nxt.wdata   = cmd_wdata;
          cnt_nxt         = CNT_W'(SETUP_CYCLES);
          cmd_ready_nxt   = 1'b0;
          state_nxt       = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_done) begin
          noe_nxt   = cmd_q.write;
          nwe_nxt   = ~cmd_q.write;
          nio_nxt   = ~cmd_q.io;
          if (cmd_q.write) begin
            data_oe_nxt  = 1'b1;
            data_out_nxt = cmd_q.wdata;
          end
          cnt_nxt   = CNT_W'(STROBE_CYCLES - 1);
          state_nxt = ST_STROBE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_STROBE: begin
        if (cnt_done) begin
          noe_nxt = 1'b1;
          nwe_nxt = 1'b1;
          if (!cmd_q.write) begin
            rsp_rdata_nxt = DataIn;
          end
          cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
          state_nxt = ST_HOLD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (cnt_done) begin
          nio_nxt       = 1'b1;
          data_oe_nxt   = 1'b0;
          rsp_valid_nxt = ~cmd_q.write;
          cmd_ready_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_swan_bus_master.sv
// Directed bench for swan_bus_master: default timing instance plus a 1/1/1 instance.
module tb_swan_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cmd_valid, cmd_valid2;
  logic        cmd_write, cmd_io;
  logic [8:0]  cmd_addr_lo;
  logic [3:0]  cmd_addr_hi;
  logic [15:0] cmd_wdata;
  logic [15:0] data_in;

  logic        cmd_ready, rsp_valid, n_sel, n_oe, n_we, n_io, data_oe;
  logic [15:0] rsp_rdata, data_out;
  logic [8:0]  addr_lo;
  logic [3:0]  addr_hi;

  logic        cmd_ready2, rsp_valid2, n_sel2, n_oe2, n_we2, n_io2, data_oe2;
  logic [15:0] rsp_rdata2, data_out2;
  logic [8:0]  addr_lo2;
  logic [3:0]  addr_hi2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  swan_bus_master dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_io(cmd_io), .cmd_addr_lo(cmd_addr_lo),
    .cmd_addr_hi(cmd_addr_hi), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .nSel(n_sel), .nOE(n_oe), .nWE(n_we), .nIO(n_io),
    .AddrLo(addr_lo), .AddrHi(addr_hi), .DataOut(data_out), .DataOe(data_oe),
    .DataIn(data_in)
  );

  swan_bus_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_write(cmd_write), .cmd_io(cmd_io), .cmd_addr_lo(cmd_addr_lo),
    .cmd_addr_hi(cmd_addr_hi), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid2),
    .rsp_rdata(rsp_rdata2), .nSel(n_sel2), .nOE(n_oe2), .nWE(n_we2), .nIO(n_io2),
    .AddrLo(addr_lo2), .AddrHi(addr_hi2), .DataOut(data_out2), .DataOe(data_oe2),
    .DataIn(data_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic wr, input logic io, input logic [3:0] hi,
                         input logic [8:0] lo, input logic [15:0] wd);
    cmd_write   = wr;
    cmd_io      = io;
    cmd_addr_hi = hi;
    cmd_addr_lo = lo;
    cmd_wdata   = wd;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    set_cmd(1'b0, 1'b0, 4'h0, 9'h000, 16'h0000);
    data_in = 16'h0000;
    repeat (3) tick();

    // Reset values
    chk1("rst_nsel", n_sel, 1'b1);
    chk1("rst_noe", n_oe, 1'b1);
    chk1("rst_nwe", n_we, 1'b1);
    chk1("rst_nio", n_io, 1'b1);
    chk16("rst_addr_lo", 16'(addr_lo), 16'h0000);
    chk16("rst_addr_hi", 16'(addr_hi), 16'h0000);
    chk16("rst_data_out", data_out, 16'h0000);
    chk1("rst_data_oe", data_oe, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk16("rst_rsp_rdata", rsp_rdata, 16'h0000);
    chk1("rst_cmd_ready", cmd_ready, 1'b1);

    rst = 1'b0; enable = 1'b1;
    tick();
    chk1("nsel_enable", n_sel, 1'b0);

    // Memory read F/0F0 returning A55A
    set_cmd(1'b0, 1'b0, 4'hF, 9'h0F0, 16'h0000);
    data_in = 16'hA55A; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk1("rd_ready_low", cmd_ready, 1'b0);
    chk16("rd_addr_hi", 16'(addr_hi), 16'h000F);
    chk16("rd_addr_lo", 16'(addr_lo), 16'h00F0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 7) data_in = 16'h0000;
      chk1($sformatf("rd_noe_k%0d", k), n_oe, !(k >= 3 && k <= 6));
      chk1($sformatf("rd_nwe_k%0d", k), n_we, 1'b1);
      chk1($sformatf("rd_nio_k%0d", k), n_io, 1'b1);
      chk1($sformatf("rd_rsp_valid_k%0d", k), rsp_valid, k == 9);
    end
    chk16("rd_rdata", rsp_rdata, 16'hA55A);
    chk16("rd_addr_held", 16'(addr_lo), 16'h00F0);

    // I/O write E/001 data 0002
    set_cmd(1'b1, 1'b1, 4'hE, 9'h001, 16'h0002);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk1("wr_nio_setup", n_io, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk1($sformatf("wr_nwe_k%0d", k), n_we, !(k >= 3 && k <= 6));
      chk1($sformatf("wr_nio_k%0d", k), n_io, !(k >= 3 && k <= 8));
      chk1($sformatf("wr_data_oe_k%0d", k), data_oe, (k >= 3 && k <= 8));
      chk1($sformatf("wr_noe_k%0d", k), n_oe, 1'b1);
      chk1($sformatf("wr_rsp_valid_k%0d", k), rsp_valid, 1'b0);
      if (k >= 3 && k <= 8) chk16($sformatf("wr_data_out_k%0d", k), data_out, 16'h0002);
    end

    // Back-to-back I/O write then I/O read with cmd_valid held
    set_cmd(1'b1, 1'b1, 4'h3, 9'h155, 16'hBEEF);
    cmd_valid = 1'b1;
    tick();
    set_cmd(1'b0, 1'b1, 4'h2, 9'h0AA, 16'h0000);
    data_in = 16'h1234;
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (k == 10) cmd_valid = 1'b0;
      chk1($sformatf("b2b_not_both_k%0d", k), !n_oe && !n_we, 1'b0);
      if (k <= 10) chk1($sformatf("b2b_ready_k%0d", k), cmd_ready, k == 9);
      chk1($sformatf("b2b_nwe_k%0d", k), n_we, !(k >= 3 && k <= 6));
      chk1($sformatf("b2b_noe_k%0d", k), n_oe, !(k >= 13 && k <= 16));
      chk1($sformatf("b2b_nio_k%0d", k), n_io, !((k >= 3 && k <= 8) || (k >= 13 && k <= 18)));
      chk1($sformatf("b2b_rsp_valid_k%0d", k), rsp_valid, k == 19);
    end
    chk16("b2b_rdata", rsp_rdata, 16'h1234);
    chk16("b2b_addr_lo", 16'(addr_lo), 16'h00AA);

    // enable dropped mid-STROBE: nSel follows only once back in IDLE
    set_cmd(1'b0, 1'b0, 4'h1, 9'h010, 16'h0000);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 4) enable = 1'b0;
      chk1($sformatf("en_nsel_k%0d", k), n_sel, k >= 10);
    end

    // Reset pulse in the middle of an I/O read strobe
    set_cmd(1'b0, 1'b1, 4'h5, 9'h123, 16'h0000);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    chk1("mr_noe_before", n_oe, 1'b0);
    chk1("mr_nio_before", n_io, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("mr_noe", n_oe, 1'b1);
    chk1("mr_nwe", n_we, 1'b1);
    chk1("mr_nio", n_io, 1'b1);
    chk1("mr_data_oe", data_oe, 1'b0);
    chk1("mr_rsp_valid", rsp_valid, 1'b0);
    chk1("mr_cmd_ready", cmd_ready, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk1($sformatf("mr_quiet_rsp_k%0d", k), rsp_valid, 1'b0);
      chk1($sformatf("mr_quiet_noe_k%0d", k), n_oe, 1'b1);
    end

    // Minimum 1/1/1 timing on the second instance
    set_cmd(1'b0, 1'b0, 4'h7, 9'h1FF, 16'h0000);
    data_in = 16'hC3C3; cmd_valid2 = 1'b1;
    tick();
    cmd_valid2 = 1'b0;
    chk1("min_ready_low", cmd_ready2, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) data_in = 16'h0000;
      chk1($sformatf("min_noe_k%0d", k), n_oe2, k != 2);
      chk1($sformatf("min_rsp_valid_k%0d", k), rsp_valid2, k == 4);
      chk1($sformatf("min_ready_k%0d", k), cmd_ready2, k >= 4);
    end
    chk16("min_rdata", rsp_rdata2, 16'hC3C3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/swan_bus_master.md
# swan_bus_master

Synthesizable initiator for the WonderSwan cartridge bus: the host side of the interface the nileswan cartridge logic responds to. Accepts read/write commands for memory or I/O space and drives `nSel`/`nOE`/`nWE`/`nIO`, `AddrLo`/`AddrHi` and the 16-bit data bus with programmable setup/strobe/hold phases. Read data is returned on a single-cycle response strobe. Used for hardware-in-the-loop testing of the cartridge and as a reusable bus-functional driver in benches.

## Interface
- `SETUP_CYCLES`, default 2: clk cycles of address setup before the strobe (≥1).
- `STROBE_CYCLES`, default 4: clk cycles `nOE`/`nWE` are held low (≥1).
- `HOLD_CYCLES`, default 2: clk cycles after the strobe rises, before the next command (≥1).
- `clk`  in  1  sole clock; all logic rises on it.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  cartridge select request; drives `nSel`.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_io`  in  1  1 = I/O space (`nIO` low), 0 = memory.
- `cmd_addr_lo`  in  9  value for `AddrLo`.
- `cmd_addr_hi`  in  4  value for `AddrHi`.
- `cmd_wdata`  in  16  write data.
- `rsp_valid`  out  1  one-cycle pulse carrying read data.
- `rsp_rdata`  out  16  captured read data.
- `nSel`, `nOE`, `nWE`, `nIO`  out  1 each  cartridge bus strobes, active-low.
- `AddrLo`  out  9;  `AddrHi`  out  4  cartridge address.
- `DataOut`  out  16;  `DataOe`  out  1;  `DataIn`  in  16  split tristate data bus.

## Operation
- States: IDLE, SETUP, STROBE, HOLD. One down-counter sized for max(SETUP, STROBE, HOLD).
- IDLE: `cmd_ready`=1. On accept: latch command, drive `AddrLo`/`AddrHi`, load `SETUP_CYCLES`, go SETUP.
- SETUP: address stable, strobes high. On count expiry: load `STROBE_CYCLES`, go STROBE.
- STROBE: `nOE`=0 (read) or `nWE`=0 (write); `nIO`=0 if `cmd_io`. Writes: `DataOe`=1, `DataOut`=wdata. On expiry: reads capture `DataIn` into `rsp_rdata`; load `HOLD_CYCLES`; go HOLD.
- HOLD: `nOE`/`nWE` high; `nIO` stays low for I/O commands; write data and `DataOe` stay driven. On expiry: `nIO`=1, `DataOe`=0; reads pulse `rsp_valid`; go IDLE.
- `nSel` = ~`enable`, sampled only in IDLE; a change of `enable` mid-transaction takes effect on return to IDLE.
- `AddrLo`/`AddrHi` keep the last command's value until the next accept.
- `cmd_ready` is 0 outside IDLE; `cmd_valid` there is ignored and not lost (held by the requester).

## Timing
- All outputs registered. Reset values: `nSel`=`nOE`=`nWE`=`nIO`=1, `AddrLo`=0, `AddrHi`=0, `DataOut`=0, `DataOe`=0, `rsp_valid`=0, `rsp_rdata`=0, `cmd_ready`=1, state IDLE.
- Accept at edge N: address valid from N+1; strobe falls at N+1+SETUP; rises at N+1+SETUP+STROBE.
- `DataIn` is sampled on the last STROBE edge, i.e. while the strobe is still low.
- `rsp_valid` is high for exactly one cycle on the edge that returns to IDLE: N+1+SETUP+STROBE+HOLD.
- Total occupancy per command: 1+SETUP+STROBE+HOLD cycles; the next accept is possible on the cycle after `rsp_valid`/HOLD end.
- `nOE` and `nWE` are never low at the same time. `nIO` is high during SETUP.
- `rst` mid-transaction: all strobes deassert, `DataOe`=0, no `rsp_valid`, state IDLE on the next edge.

## Structure
- `swan_bus_pkg`: state enum, command struct (write, io, addr_lo, addr_hi, wdata), default phase constants.
- No sub-module needed; the counter and FSM live in one module.

## Test plan
- Reset, then read `cmd_addr_hi`=F, `cmd_addr_lo`=0F0 with `DataIn`=16'hA55A -> `nOE` low for 4 cycles starting 3 cycles after accept, `rsp_rdata`=A55A, `rsp_valid` pulses once at cycle 9.
- I/O write to E/001 with data 0002 -> `nIO` and `nWE` fall together, `DataOe`=1 through HOLD, `nIO` rises after 2 HOLD cycles, no `rsp_valid`.
- Back-to-back I/O write then I/O read with `cmd_valid` held -> second accept on the cycle after the first HOLD; `nOE`/`nWE` never both low.
- `enable` toggled 1->0 during STROBE -> `nSel` stays unchanged until IDLE, then goes 1.
- Assert `rst` for one cycle mid-STROBE of a read -> all strobes 1 and `DataOe`=0 next edge, no `rsp_valid`, `cmd_ready`=1.
- `SETUP_CYCLES`=1, `STROBE_CYCLES`=1, `HOLD_CYCLES`=1 -> read completes with `rsp_valid` 4 cycles after accept.
